// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - decode-to-execute bundle, hazard stall and bubble counter
interface id_ex_pipe_reg_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             id_valid;
  logic [5:0]       id_op;
  logic [5:0]       id_funct;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic [DW-1:0]    id_rs_data;
  logic [DW-1:0]    id_rt_data;
  logic [DW-1:0]    id_ext_immed;
  logic [DW-1:0]    id_pc4;

  logic             stall;
  logic             ex_valid;
  logic [5:0]       ex_op;
  logic [5:0]       ex_funct;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_dst;
  logic [DW-1:0]    ex_rs_data;
  logic [DW-1:0]    ex_rt_data;
  logic [DW-1:0]    ex_immed;
  logic [DW-1:0]    ex_pc4;
  logic             ex_alu_src;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_reg_write;
  logic             ex_branch;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output flush, id_valid, id_op, id_funct, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_ext_immed, id_pc4,
    input  stall, ex_valid, ex_op, ex_funct, ex_rs, ex_rt, ex_dst,
           ex_rs_data, ex_rt_data, ex_immed, ex_pc4, ex_alu_src,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, bubble_cnt
  );

  modport slave (
    input  flush, id_valid, id_op, id_funct, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_ext_immed, id_pc4,
    output stall, ex_valid, ex_op, ex_funct, ex_rs, ex_rt, ex_dst,
           ex_rs_data, ex_rt_data, ex_immed, ex_pc4, ex_alu_src,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with EX control decode and load-use hazard bubble
module id_ex_pipe_reg #(
  parameter int         DW     = 32,
  parameter int         CNT_W  = 16,
  parameter logic [5:0] R_TYPE = 6'd0,
  parameter logic [5:0] BEQ    = 6'd4,
  parameter logic [5:0] LW     = 6'd35,
  parameter logic [5:0] SW     = 6'd43
) (
  input  logic               clk,
  input  logic               rst,
  id_ex_pipe_reg_if.slave    bus
);

  logic             valid_q,     valid_d;
  logic [5:0]       op_q,        op_d;
  logic [5:0]       funct_q,     funct_d;
  logic [4:0]       rs_q,        rs_d;
  logic [4:0]       rt_q,        rt_d;
  logic [4:0]       dst_q,       dst_d;
  logic [DW-1:0]    rs_data_q,   rs_data_d;
  logic [DW-1:0]    rt_data_q,   rt_data_d;
  logic [DW-1:0]    immed_q,     immed_d;
  logic [DW-1:0]    pc4_q,       pc4_d;
  logic             alu_src_q,   alu_src_d;
  logic             mem_read_q,  mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             reg_write_q, reg_write_d;
  logic             branch_q,    branch_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic       is_r, is_beq, is_lw, is_sw;
  logic [4:0] dec_dst;
  logic       stall_w;

  assign is_r    = (bus.id_op == R_TYPE);
  assign is_beq  = (bus.id_op == BEQ);
  assign is_lw   = (bus.id_op == LW);
  assign is_sw   = (bus.id_op == SW);
  assign dec_dst = is_r ? bus.id_rd : (is_lw ? bus.id_rt : 5'd0);

  // lw does not read rt, so only its rs can collide with the load in EX
  assign stall_w = valid_q && mem_read_q && (rt_q != 5'd0) && bus.id_valid &&
                   ((rt_q == bus.id_rs) || ((rt_q == bus.id_rt) && !is_lw));

  always_comb begin
    valid_d     = valid_q;
    op_d        = op_q;
    funct_d     = funct_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    dst_d       = dst_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    immed_d     = immed_q;
    pc4_d       = pc4_q;
    alu_src_d   = alu_src_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    reg_write_d = reg_write_q;
    branch_d    = branch_q;
    cnt_d       = cnt_q;
    if (bus.flush || stall_w) begin
      valid_d     = 1'b0;
      alu_src_d   = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      reg_write_d = 1'b0;
      branch_d    = 1'b0;
      if (!bus.flush && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      valid_d     = bus.id_valid;
      op_d        = bus.id_op;
      funct_d     = bus.id_funct;
      rs_d        = bus.id_rs;
      rt_d        = bus.id_rt;
      dst_d       = dec_dst;
      rs_data_d   = bus.id_rs_data;
      rt_data_d   = bus.id_rt_data;
      immed_d     = bus.id_ext_immed;
      pc4_d       = bus.id_pc4;
      // invalid slots carry no side effects downstream
      alu_src_d   = bus.id_valid && (is_lw || is_sw);
      mem_read_d  = bus.id_valid && is_lw;
      mem_write_d = bus.id_valid && is_sw;
      reg_write_d = bus.id_valid && (is_r || is_lw) && (dec_dst != 5'd0);
      branch_d    = bus.id_valid && is_beq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      op_q        <= '0;
      funct_q     <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      dst_q       <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      immed_q     <= '0;
      pc4_q       <= '0;
      alu_src_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      branch_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      op_q        <= op_d;
      funct_q     <= funct_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      dst_q       <= dst_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      immed_q     <= immed_d;
      pc4_q       <= pc4_d;
      alu_src_q   <= alu_src_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      branch_q    <= branch_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.stall        = stall_w;
  assign bus.ex_valid     = valid_q;
  assign bus.ex_op        = op_q;
  assign bus.ex_funct     = funct_q;
  assign bus.ex_rs        = rs_q;
  assign bus.ex_rt        = rt_q;
  assign bus.ex_dst       = dst_q;
  assign bus.ex_rs_data   = rs_data_q;
  assign bus.ex_rt_data   = rt_data_q;
  assign bus.ex_immed     = immed_q;
  assign bus.ex_pc4       = pc4_q;
  assign bus.ex_alu_src   = alu_src_q;
  assign bus.ex_mem_read  = mem_read_q;
  assign bus.ex_mem_write = mem_write_q;
  assign bus.ex_reg_write = reg_write_q;
  assign bus.ex_branch    = branch_q;
  assign bus.bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed and randomized checks of id_ex_pipe_reg against an instruction-level model
module tb_id_ex_pipe_reg;
  localparam int DW    = 32;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.DW(DW), .CNT_W(CNT_W)) bus ();
  id_ex_pipe_reg #(.DW(DW), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // instruction in EX as the model sees it
  typedef struct {
    bit          valid;
    bit [5:0]    op, funct;
    bit [4:0]    rs, rt, dst;
    bit [DW-1:0] rsd, rtd, imm, pc4;
    bit          alu_src, mr, mw, rw, br;
  } ex_t;
  ex_t m;
  int  m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input bit v, input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt,
                        input bit [4:0] rd, input bit [DW-1:0] rsd, input bit [DW-1:0] rtd,
                        input bit fl);
    bus.id_valid     = v;
    bus.id_op        = op;
    bus.id_funct     = 6'($urandom);
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_rs_data   = rsd;
    bus.id_rt_data   = rtd;
    bus.id_ext_immed = $urandom;
    bus.id_pc4       = $urandom;
    bus.flush        = fl;
  endtask

  function automatic bit model_stall();
    return m.valid && m.mr && m.rt != 0 && bus.id_valid &&
           (m.rt == bus.id_rs || (m.rt == bus.id_rt && bus.id_op != 6'd35));
  endfunction

  task automatic model_next(input bit st);
    ex_t n;
    n = m;
    if (rst) begin
      n = '{default: 0};
      m_cnt = 0;
    end else if (bus.flush || st) begin
      n.valid = 0; n.alu_src = 0; n.mr = 0; n.mw = 0; n.rw = 0; n.br = 0;
      if (!bus.flush && m_cnt < CMAX) m_cnt++;
    end else begin
      n.valid = bus.id_valid;
      n.op = bus.id_op; n.funct = bus.id_funct; n.rs = bus.id_rs; n.rt = bus.id_rt;
      n.rsd = bus.id_rs_data; n.rtd = bus.id_rt_data; n.imm = bus.id_ext_immed; n.pc4 = bus.id_pc4;
      n.alu_src = 0; n.mr = 0; n.mw = 0; n.rw = 0; n.br = 0;
      case (bus.id_op)
        6'd0:    n.dst = bus.id_rd;
        6'd35:   n.dst = bus.id_rt;
        default: n.dst = 0;
      endcase
      if (bus.id_valid) begin
        case (bus.id_op)
          6'd0:  n.rw = (n.dst != 0);
          6'd4:  n.br = 1;
          6'd35: begin n.mr = 1; n.alu_src = 1; n.rw = (n.dst != 0); end
          6'd43: begin n.mw = 1; n.alu_src = 1; end
          default: ;
        endcase
      end
    end
    m = n;
  endtask

  // inputs are already applied; check stall, clock once, check EX state
  task automatic step();
    bit st;
    #1;
    st = model_stall();
    chk("stall", bus.stall, st);
    model_next(st);
    @(posedge clk);
    #1;
    chk("ex_valid",   bus.ex_valid,     m.valid);
    chk("ex_op",      bus.ex_op,        m.op);
    chk("ex_funct",   bus.ex_funct,     m.funct);
    chk("ex_rs",      bus.ex_rs,        m.rs);
    chk("ex_rt",      bus.ex_rt,        m.rt);
    chk("ex_dst",     bus.ex_dst,       m.dst);
    chk("ex_rs_data", bus.ex_rs_data,   m.rsd);
    chk("ex_rt_data", bus.ex_rt_data,   m.rtd);
    chk("ex_immed",   bus.ex_immed,     m.imm);
    chk("ex_pc4",     bus.ex_pc4,       m.pc4);
    chk("alu_src",    bus.ex_alu_src,   m.alu_src);
    chk("mem_read",   bus.ex_mem_read,  m.mr);
    chk("mem_write",  bus.ex_mem_write, m.mw);
    chk("reg_write",  bus.ex_reg_write, m.rw);
    chk("branch",     bus.ex_branch,    m.br);
    chk("bubble_cnt", bus.bubble_cnt,   m_cnt);
  endtask

  task automatic do_reset();
    rst = 1;
    set_in(1, 6'd35, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, 0);
    step();
    step();
    rst = 0;
  endtask

  int sat_exp[4] = '{1, 2, 3, 3};
  bit [5:0] ops[5] = '{6'd0, 6'd4, 6'd35, 6'd43, 6'd17};

  initial begin
    m = '{default: 0};
    m_cnt = 0;
    rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    // T1 reset
    do_reset();
    chk("t1_valid", bus.ex_valid, 0);
    chk("t1_mr", bus.ex_mem_read, 0);
    chk("t1_rw", bus.ex_reg_write, 0);
    chk("t1_data", bus.ex_rs_data, 0);
    chk("t1_cnt", bus.bubble_cnt, 0);
    chk("t1_stall", bus.stall, 0);

    // T2 R-type pass-through
    set_in(1, 6'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 0);
    step();
    chk("t2_dst", bus.ex_dst, 3);
    chk("t2_rw", bus.ex_reg_write, 1);
    chk("t2_alu_src", bus.ex_alu_src, 0);
    chk("t2_rsd", bus.ex_rs_data, 5);
    chk("t2_rtd", bus.ex_rt_data, 7);
    chk("t2_stall", bus.stall, 0);

    // T3 load-use
    set_in(1, 6'd35, 5'd4, 5'd8, 5'd0, 1, 2, 0);
    step();
    set_in(1, 6'd0, 5'd8, 5'd1, 5'd2, 11, 12, 0);
    #1 chk("t3_stall", bus.stall, 1);
    step();
    chk("t3_bubble", bus.ex_valid, 0);
    chk("t3_cnt", bus.bubble_cnt, 1);
    chk("t3_stall_drop", bus.stall, 0);
    step();
    chk("t3_add_valid", bus.ex_valid, 1);
    chk("t3_add_op", bus.ex_op, 0);

    // T4 no false stall
    set_in(1, 6'd35, 5'd4, 5'd8, 5'd0, 1, 2, 0);
    step();
    set_in(1, 6'd35, 5'd9, 5'd8, 5'd0, 1, 2, 0);
    #1 chk("t4_lw_rt", bus.stall, 0);
    step();
    set_in(1, 6'd35, 5'd4, 5'd0, 5'd0, 1, 2, 0);
    step();
    set_in(1, 6'd0, 5'd0, 5'd0, 5'd5, 1, 2, 0);
    #1 chk("t4_zero", bus.stall, 0);
    step();

    // T5 flush beats stall
    set_in(1, 6'd35, 5'd4, 5'd6, 5'd0, 1, 2, 0);
    step();
    set_in(1, 6'd4, 5'd6, 5'd1, 5'd0, 1, 2, 1);
    #1 chk("t5_stall", bus.stall, 1);
    step();
    chk("t5_valid", bus.ex_valid, 0);
    chk("t5_branch", bus.ex_branch, 0);
    chk("t5_cnt", bus.bubble_cnt, 1);

    // T6 saturation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 6'd35, 5'd1, 5'd5, 5'd0, $urandom, $urandom, 0);
      step();
      set_in(1, 6'd0, 5'd5, 5'd2, 5'd3, $urandom, $urandom, 0);
      step();
      chk("t6_cnt", bus.bubble_cnt, sat_exp[i]);
      step();
    end

    // randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 7) != 0, ops[$urandom_range(0, 4)],
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom, $urandom, $urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
